fibo_gen_param: RTL and testbench

- Parametrised, handshaked Fibonacci sequence generator.
- On `start` it loads two programmable seeds and emits `num_terms` terms of the sequence, one per accepted valid/ready transfer.
- Detects adder carry-out, then stops or wraps according to build configuration.
- Sits in the Fibonacci generator family as the general-width, streaming-output successor to the fixed 4-bit free-running generator.

---
 rtl/fibo_gen_param.sv | 161 ++++++++++++++++
 tb/tb_fibo_gen_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_gen_param.sv
// -----------------------------------------------------------------------------
// fibo_gen_param
//
// Parametrised, handshaked Fibonacci sequence generator. A start request in
// IDLE latches two seeds and a term count; the generator then streams that many
// terms of the sequence over a valid/ready output, one term per transfer.
// A carry out of the WIDTH-bit adder is flagged on the sticky overflow output.
//
// Build option:
//   FIBO_WRAP_EN  undefined (default): a term produced with a carry is never
//                 presented; the sequence ends early once that term would be
//                 next.
//                 defined: arithmetic wraps modulo 2^WIDTH and exactly
//                 num_terms terms are always emitted.
//
// Parameters:
//   WIDTH      term width in bits (adder is WIDTH+1 bits internally)
//   CNT_W      width of the term count and index
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      request a new sequence (sampled only in IDLE)
//   seed0      first term F0 (sampled with start)
//   seed1      second term F1 (sampled with start)
//   num_terms  number of terms to emit (sampled with start)
//   out_ready  consumer accepts fibo_term this cycle
//   out_valid  fibo_term holds a valid term
//   fibo_term  current term
//   term_idx   index of fibo_term, starting at 0
//   busy       high whenever the generator is not IDLE
//   done       one-cycle pulse when a sequence ends
//   overflow   sticky adder carry flag for the current sequence
//
// Handshake: a transfer happens on a rising edge where out_valid and out_ready
// are both 1. out_valid never depends on out_ready, and while out_valid is high
// without out_ready, fibo_term and term_idx hold their values indefinitely.
// -----------------------------------------------------------------------------
module fibo_gen_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seed0,
   input  logic [WIDTH-1:0] seed1,
   input  logic [CNT_W-1:0] num_terms,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] fibo_term,
   output logic [CNT_W-1:0] term_idx,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

`ifdef FIBO_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a;        // current term, shown on fibo_term
   logic [WIDTH-1:0] b;        // next term
   logic             b_ovf;    // b was produced with a carry
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] len;
   logic             ovf;

   logic [WIDTH:0]   sum;
   logic             load;
   logic             xfer;

   assign sum = {1'b0, a} + {1'b0, b};

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = (num_terms != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (out_ready) begin
               xfer = 1'b1;
               if (idx == len - CNT_W'(1)) begin
                  state_nxt = DONE;
               end else if (b_ovf && !WRAP_EN) begin
                  // The term about to move into a is corrupt: stop before
                  // presenting it. overflow was set when b was produced.
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         a     <= '0;
         b     <= '0;
         b_ovf <= 1'b0;
         idx   <= '0;
         len   <= '0;
         ovf   <= 1'b0;
      end else if (load) begin
         a     <= seed0;
         b     <= seed1;
         b_ovf <= 1'b0;
         idx   <= '0;
         len   <= num_terms;
         ovf   <= 1'b0;
      end else if (xfer) begin
         a     <= b;
         b     <= sum[WIDTH-1:0];
         b_ovf <= sum[WIDTH];
         idx   <= idx + CNT_W'(1);
         if (sum[WIDTH]) begin
            ovf <= 1'b1;
         end
      end
   end

   assign out_valid = (state == RUN);
   assign fibo_term = a;
   assign term_idx  = idx;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign overflow  = ovf;

endmodule

// File: tb/tb_fibo_gen_param.sv
// -----------------------------------------------------------------------------
// tb_fibo_gen_param
//
// Self-checking bench for fibo_gen_param (WIDTH=8, CNT_W=8). Expected terms and
// overflow flags come from a reference model that builds the sequence with
// plain integer arithmetic; the generator is checked every cycle of each run.
// The reference honours FIBO_WRAP_EN the same way the design build does.
// -----------------------------------------------------------------------------
module tb_fibo_gen_param;

   localparam int W  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  seed0 = '0;
   logic [W-1:0]  seed1 = '0;
   logic [CW-1:0] num_terms = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [W-1:0]  fibo_term;
   logic [CW-1:0] term_idx;
   logic          busy;
   logic          done;
   logic          overflow;

   int tests = 0;
   int fails = 0;

   // Reference model output: terms in order, and overflow expected while
   // each term is presented.
   logic [W-1:0] exp_q[$];
   bit           ovf_q[$];
   bit           final_ovf;

   fibo_gen_param #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .seed0     (seed0),
      .seed1     (seed1),
      .num_terms (num_terms),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .fibo_term (fibo_term),
      .term_idx  (term_idx),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},    32'(out_valid), 32'(0));
      check({tag, "_term"},     32'(fibo_term), 32'(0));
      check({tag, "_idx"},      32'(term_idx),  32'(0));
      check({tag, "_busy"},     32'(busy),      32'(0));
      check({tag, "_done"},     32'(done),      32'(0));
      check({tag, "_overflow"}, 32'(overflow),  32'(0));
   endtask

   // Fibonacci reference: F(k+2) = F(k) + F(k+1). A sum that does not fit in
   // W bits sets overflow; without wrap, such a term is never emitted.
   task automatic build_model(input int s0, input int s1, input int n);
      longint x;
      longint y;
      longint s;
      bit     c;
      bit     ov;
      bit     y_bad;
      x = s0;
      y = s1;
      ov = 1'b0;
      y_bad = 1'b0;
      exp_q.delete();
      ovf_q.delete();
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(W'(x));
         ovf_q.push_back(ov);
         s = x + y;
         c = (s >= (longint'(1) << W));
         ov = ov | c;
`ifndef FIBO_WRAP_EN
         if (y_bad) break;
`endif
         x = y;
         y = s % (longint'(1) << W);
         y_bad = c;
      end
      final_ovf = ov;
   endtask

   // ---------------- driver ----------------
   // mode 0: out_ready always 1
   // mode 1: random out_ready
   // mode 2: stall 3 cycles while term idx 2 is shown
   // mode 3: out_ready always 1, plus start pulses (seed0=99) mid-run and in DONE
   // abort_at >= 0: drive reset low while that term index is presented
   task automatic run_seq(input int s0, input int s1, input int n, input int mode,
                          input int abort_at);
      int k;
      int stall;
      int budget;
      bit rdy;
      k = 0;
      stall = 0;
      budget = 0;
      build_model(s0, s1, n);

      @(negedge clk);
      start = 1'b1;
      seed0 = W'(s0);
      seed1 = W'(s1);
      num_terms = CW'(n);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs: they must not be resampled during the run.
      seed0 = W'($urandom);
      seed1 = W'($urandom);
      num_terms = CW'($urandom);
      check("busy_after_start", 32'(busy), 32'(1));

      while (k < exp_q.size()) begin
         if (budget > 2000) begin
            check("timeout", 32'(0), 32'(1));
            break;
         end
         budget++;
         if (k == abort_at) begin
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("reset_mid");
            reset = 1'b1;
            return;
         end
         check("valid",    32'(out_valid), 32'(1));
         check("term",     32'(fibo_term), 32'(exp_q[k]));
         check("idx",      32'(term_idx),  k);
         check("overflow", 32'(overflow),  32'(ovf_q[k]));
         check("done_run", 32'(done),      32'(0));
         case (mode)
            1: rdy = ($urandom_range(0, 3) != 0);
            2: begin
               rdy = !(k == 2 && stall < 3);
               if (!rdy) stall++;
            end
            default: rdy = 1'b1;
         endcase
         if (mode == 3 && k == 1) begin
            start = 1'b1;
            seed0 = W'(99);
         end
         out_ready = rdy;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (rdy) k++;
      end

      out_ready = 1'($urandom_range(0, 1));
      check("done_pulse",   32'(done),      32'(1));
      check("done_valid",   32'(out_valid), 32'(0));
      check("done_busy",    32'(busy),      32'(1));
      check("done_overflow", 32'(overflow), 32'(final_ovf));
      if (mode == 3) begin
         start = 1'b1;
         seed0 = W'(99);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("idle_done",     32'(done),      32'(0));
      check("idle_busy",     32'(busy),      32'(0));
      check("idle_valid",    32'(out_valid), 32'(0));
      check("idle_overflow", 32'(overflow),  32'(final_ovf));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Basic sequence 0,1,1,2,...,34
      run_seq(0, 1, 10, 0, -1);
      // Overflow stop (or wrap with FIBO_WRAP_EN)
      run_seq(0, 1, 20, 0, -1);
      // Backpressure at idx 2
      run_seq(2, 3, 5, 2, -1);
      // Zero length
      run_seq(5, 7, 0, 0, -1);
      // Start while busy and in DONE is ignored
      run_seq(0, 1, 10, 3, -1);
      // Reset mid-run at idx 4, then a fresh run
      run_seq(0, 1, 10, 0, 4);
      @(negedge clk);
      check("reset_idle_busy", 32'(busy), 32'(0));
      run_seq(0, 1, 10, 0, -1);
      // Seeds overflowing on the first add
      run_seq(200, 100, 8, 0, -1);
      // Maximum term count
      run_seq(0, 1, 255, 0, -1);
      run_seq(1, 0, 255, 1, -1);

      // Randomized runs
      for (int r = 0; r < 30; r++) begin
         run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 40)), int'($urandom_range(0, 1)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
